// File: rtl/imgproc_pkg.sv
// Shared image-processing types and defaults.
// Used by the threshold generator and its bias adder.
package imgproc_pkg;

  localparam int PIX_W_DEFAULT       = 8;
  localparam int LOG2_PIXELS_DEFAULT = 16;
  localparam int THR_INIT_DEFAULT    = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CALC  = 2'd2
  } thr_state_e;

endpackage

// File: rtl/sat_add_bias.sv
// Adds a signed bias to an unsigned mean.
// The result is clamped to the unsigned pixel range.
module sat_add_bias #(
  parameter int W = 8
) (
  input  logic [W-1:0] mean,
  input  logic [W-1:0] bias,
  output logic [W-1:0] sum_sat
);

  logic signed [W+1:0] a;
  logic signed [W+1:0] b;
  logic signed [W+1:0] s;

  assign a = $signed({2'b00, mean});
  assign b = $signed({{2{bias[W-1]}}, bias});
  assign s = a + b;

  always_comb begin
    sum_sat = s[W-1:0];
    if (s[W+1]) begin
      sum_sat = '0;
    end else if (s[W]) begin
      sum_sat = '1;
    end
  end

endmodule

// File: rtl/mean_threshold_gen.sv
// Per-frame mean of pixels published as the next frame's threshold.
// Define THRESHOLD_BIAS_EN to add a saturating signed bias port.
module mean_threshold_gen
  import imgproc_pkg::*;
#(
  parameter int PIX_W       = PIX_W_DEFAULT,
  parameter int LOG2_PIXELS = LOG2_PIXELS_DEFAULT,
  parameter int THR_INIT    = THR_INIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
`ifdef THRESHOLD_BIAS_EN
  input  logic [PIX_W-1:0] bias,
`endif
  output logic [PIX_W-1:0] thr_out,
  output logic             thr_valid,
  output logic             busy
);

  localparam int SUM_W = PIX_W + LOG2_PIXELS;
  localparam int CNT_W = LOG2_PIXELS + 1;
  localparam logic [CNT_W-1:0] CNT_FULL =
    {1'b1, {LOG2_PIXELS{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  thr_state_e state;
  thr_state_e state_nxt;

  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_pix;
  logic             seed_last;
  logic             accum_en;
  logic             calc_en;
  logic [PIX_W-1:0] mean;
  logic [PIX_W-1:0] thr_calc;

  assign cnt_inc   = cnt + CNT_ONE;
  assign last_pix  = (cnt_inc == CNT_FULL);
  assign seed_last = (CNT_FULL == CNT_ONE);
  assign mean      = sum[SUM_W-1:LOG2_PIXELS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A restart wins over any in-flight completion.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = (pix_valid && seed_last)
                    ? CALC : ACCUM;
        end
      end
      ACCUM: begin
        if (frame_start) begin
          state_nxt = (pix_valid && seed_last)
                    ? CALC : ACCUM;
        end else if (pix_valid && last_pix) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (frame_start) begin
          state_nxt = (pix_valid && seed_last)
                    ? CALC : ACCUM;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    accum_en = 1'b0;
    calc_en  = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
      end
      ACCUM: begin
        busy     = 1'b1;
        accum_en = pix_valid && !frame_start;
      end
      CALC: begin
        busy    = 1'b1;
        calc_en = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      cnt <= '0;
    end else begin
      unique case (1'b1)
        frame_start: begin
          sum <= pix_valid ? SUM_W'(pix_data) : '0;
          cnt <= pix_valid ? CNT_ONE : '0;
        end
        accum_en: begin
          sum <= sum + SUM_W'(pix_data);
          cnt <= cnt_inc;
        end
        default: begin
          sum <= sum;
          cnt <= cnt;
        end
      endcase
    end
  end

`ifdef THRESHOLD_BIAS_EN
  sat_add_bias #(
    .W(PIX_W)
  ) u_sat_add_bias (
    .mean   (mean),
    .bias   (bias),
    .sum_sat(thr_calc)
  );
`else
  assign thr_calc = mean;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_out   <= PIX_W'(THR_INIT);
      thr_valid <= 1'b0;
    end else begin
      thr_valid <= calc_en;
      if (calc_en) begin
        thr_out <= thr_calc;
      end
    end
  end

endmodule

// File: tb/tb_mean_threshold_gen.sv
// Scoreboard bench for mean_threshold_gen with 16-pixel frames.
// Bias scenarios run when THRESHOLD_BIAS_EN is defined.
module tb_mean_threshold_gen;

  localparam int L = 4;
  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
`ifdef THRESHOLD_BIAS_EN
  logic [7:0] bias = '0;
`endif
  logic [7:0] thr_out;
  logic       thr_valid;
  logic       busy;

  mean_threshold_gen #(
    .PIX_W      (8),
    .LOG2_PIXELS(L),
    .THR_INIT   (128)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
`ifdef THRESHOLD_BIAS_EN
    .bias       (bias),
`endif
    .thr_out    (thr_out),
    .thr_valid  (thr_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int thr;
    int cyc;
    int busy;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && thr_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_thr_valid actual=1 expected=0 thr=%0d",
                 thr_out);
      end else begin
        mon_e = q.pop_front();
        chk("thr_out", int'(thr_out), mon_e.thr);
        chk("valid_cycle", cyc, mon_e.cyc);
        chk("busy_at_valid", int'(busy), mon_e.busy);
      end
    end
  end

  task automatic drive(input logic fs,
                       input logic pv,
                       input logic [7:0] d);
    @(posedge clk);
    #1;
    frame_start = fs;
    pix_valid   = pv;
    pix_data    = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_frame(input logic [7:0] base,
                           input logic [7:0] step,
                           input bit gap,
                           input int expv,
                           input int busy_after);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      drive(i == 0, 1'b1, base + 8'(i) * step);
      if (gap && i != N - 1) drive(1'b0, 1'b0, 8'hAA);
    end
    e.thr  = expv;
    e.cyc  = cyc + 2;
    e.busy = busy_after;
    q.push_back(e);
  endtask

  task automatic drain;
    int n;
    idle(3);
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("pending_results", q.size(), 0);
    @(negedge clk);
    chk("busy_after_frame", int'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_thr_out", int'(thr_out), 128);
    chk("rst_thr_valid", int'(thr_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // 16 x 100 back to back
    run_frame(8'd100, 8'd0, 1'b0, 100, 0);
    drain();

    // reset mid-frame after thr_out became 100
    drive(1'b1, 1'b1, 8'd9);
    repeat (4) drive(1'b0, 1'b1, 8'd9);
    @(posedge clk);
    #2;
    rst = 1'b1;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("midrst_thr_out", int'(thr_out), 128);
    chk("midrst_thr_valid", int'(thr_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    idle(2);

    // 0..15 gapped: sum 120, mean 7
    run_frame(8'd0, 8'd1, 1'b1, 7, 0);
    drain();

    // aborted frame of 200s, then 16 x 50
    drive(1'b1, 1'b1, 8'd200);
    @(negedge clk);
    chk("busy_pre_edge", int'(busy), 0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 8'd200);
      if (i == 0) begin
        @(negedge clk);
        chk("busy_rise", int'(busy), 1);
      end
    end
    run_frame(8'd50, 8'd0, 1'b0, 50, 0);
    drain();

    // back-to-back: restart lands in the CALC cycle
    run_frame(8'd255, 8'd0, 1'b0, 255, 1);
    run_frame(8'd0, 8'd0, 1'b0, 0, 0);
    drain();

    // 240..255: sum 3960, mean 247
    run_frame(8'd240, 8'd1, 1'b0, 247, 0);
    drain();

`ifdef THRESHOLD_BIAS_EN
    bias = 8'sd20;
    run_frame(8'd250, 8'd0, 1'b0, 255, 0);
    drain();
    bias = -8'sd30;
    run_frame(8'd10, 8'd0, 1'b0, 0, 0);
    drain();
    bias = -8'sd5;
    run_frame(8'd100, 8'd0, 1'b0, 95, 0);
    drain();
    bias = 8'd0;
`endif

    chk("final_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
